// File: rtl/four_way_mux_arbiter_pkg.sv
// Shared types for the four-way round-robin mux arbiter.
package four_way_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef logic [1:0] idx_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

endpackage

// File: rtl/four_way_mux_arbiter_rr_pick.sv
// Rotating-priority picker: first set req bit at or after start, wrapping 3->0.
module rr_pick
  import four_way_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  idx_t               start,
  output logic               found,
  output idx_t               idx
);

  idx_t w_cand;

  // Walk from the farthest offset down so the nearest hit is the last write.
  always_comb begin
    found  = 1'b0;
    idx    = start;
    w_cand = start;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = start + idx_t'(k);
      if (req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/four_way_mux_arbiter.sv
// Round-robin arbiter driving the s_0/s_1 select of a shared 4:1 mux.
// Optional hold limit: define FOUR_WAY_ARB_HOLD_LIMIT_EN to force rotation after MAX_HOLD cycles.
module four_way_mux_arbiter
  import four_way_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s_0,
  output logic               s_1,
  output logic               busy,
  output idx_t               owner
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("MAX_HOLD must be in 2..255");
  end

  arb_state_t         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  idx_t               r_sel, w_sel_nxt;
  idx_t               r_ptr, w_ptr_nxt;
  logic               r_busy, w_busy_nxt;

  logic [NUM_REQ-1:0] w_cand_req;
  logic               w_found;
  idx_t               w_win;
  logic               w_own_req;
  logic               w_take;

`ifdef FOUR_WAY_ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] r_hold, w_hold_nxt;
`endif

  // The owner never competes in its own handoff; in IDLE r_gnt is zero so
  // every requester is eligible. ptr tracks the owner while BUSY, so one
  // picker starting at ptr+1 serves both searches.
  assign w_cand_req = req & ~r_gnt;

  rr_pick u_pick (
    .req   (w_cand_req),
    .start (r_ptr + idx_t'(1)),
    .found (w_found),
    .idx   (w_win)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_busy_nxt  = r_busy;
    w_take      = 1'b0;
    w_own_req   = |(req & r_gnt);
    case (r_state)
      ARB_IDLE: w_take = w_found;
      ARB_BUSY: begin
        if (!w_own_req) begin
          w_take = w_found;
          if (!w_found) begin
            // Select and ptr keep their values so the mux does not glitch.
            w_state_nxt = ARB_IDLE;
            w_gnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
          end
        end
`ifdef FOUR_WAY_ARB_HOLD_LIMIT_EN
        else if (w_found && r_hold == HOLD_LAST) begin
          w_take = 1'b1;
        end
`endif
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
    if (w_take) begin
      w_state_nxt        = ARB_BUSY;
      w_gnt_nxt          = '0;
      w_gnt_nxt[w_win]   = 1'b1;
      w_sel_nxt          = w_win;
      w_ptr_nxt          = w_win;
      w_busy_nxt         = 1'b1;
    end
  end

`ifdef FOUR_WAY_ARB_HOLD_LIMIT_EN
  // Saturates at the limit so a lone owner keeps the grant indefinitely.
  always_comb begin
    w_hold_nxt = r_hold;
    if (w_take) begin
      w_hold_nxt = '0;
    end else if (r_state == ARB_BUSY && r_hold != HOLD_LAST) begin
      w_hold_nxt = r_hold + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_hold <= '0;
    else        r_hold <= w_hold_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= idx_t'(NUM_REQ - 1);
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign gnt   = r_gnt;
  assign s_0   = r_sel[1];
  assign s_1   = r_sel[0];
  assign busy  = r_busy;
  assign owner = r_sel;

endmodule

// File: tb/tb_four_way_mux_arbiter.sv
// Scoreboard bench for four_way_mux_arbiter; expectations are {gnt, sel, busy}.
module tb_four_way_mux_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s_0, s_1, busy;
  logic [1:0] owner;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  four_way_mux_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .s_0   (s_0),
    .s_1   (s_1),
    .busy  (busy),
    .owner (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    req   = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      sbq.push_back(exp_t'(7'b0000_00_0));
      @(posedge clk); @(negedge clk);
      e = sbq.pop_front(); checks++;
      if ({gnt, s_0, s_1, owner, busy} !== {e.gnt, e.sel, e.sel, e.busy}) begin
        errors++;
        $display("FAIL reset[%0d]: gnt=%b sel=%b%b owner=%0d busy=%b want gnt=%b sel=%b busy=%b",
                 k, gnt, s_0, s_1, owner, busy, e.gnt, e.sel, e.busy);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_handoff();
    logic [3:0] rq [4] = '{4'b1010, 4'b1000, 4'b1000, 4'b0000};
    logic [6:0] ex [4] = '{7'b0010_01_1, 7'b1000_11_1, 7'b1000_11_1, 7'b0000_11_0};
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      req = rq[k];
      sbq.push_back(exp_t'(ex[k]));
      @(posedge clk); @(negedge clk);
      e = sbq.pop_front(); checks++;
      if ({gnt, s_0, s_1, owner, busy} !== {e.gnt, e.sel, e.sel, e.busy}) begin
        errors++;
        $display("FAIL handoff[%0d]: gnt=%b sel=%b%b owner=%0d busy=%b want gnt=%b sel=%b busy=%b",
                 k, gnt, s_0, s_1, owner, busy, e.gnt, e.sel, e.busy);
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] rq [10] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
                            4'b1111, 4'b1011, 4'b1111, 4'b0111, 4'b0000};
    logic [6:0] ex [10] = '{7'b0001_00_1, 7'b0001_00_1, 7'b0010_01_1, 7'b0010_01_1,
                            7'b0100_10_1, 7'b0100_10_1, 7'b1000_11_1, 7'b1000_11_1,
                            7'b0001_00_1, 7'b0000_00_0};
    exp_t e;
    for (int k = 0; k < 10; k++) begin
      req = rq[k];
      sbq.push_back(exp_t'(ex[k]));
      @(posedge clk); @(negedge clk);
      e = sbq.pop_front(); checks++;
      if ({gnt, s_0, s_1, owner, busy} !== {e.gnt, e.sel, e.sel, e.busy}) begin
        errors++;
        $display("FAIL rotation[%0d]: gnt=%b sel=%b%b owner=%0d busy=%b want gnt=%b sel=%b busy=%b",
                 k, gnt, s_0, s_1, owner, busy, e.gnt, e.sel, e.busy);
      end
    end
  endtask

  task automatic test_release_idle();
    logic [3:0] rq [3] = '{4'b0100, 4'b0000, 4'b0000};
    logic [6:0] ex [3] = '{7'b0100_10_1, 7'b0000_10_0, 7'b0000_10_0};
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      req = rq[k];
      sbq.push_back(exp_t'(ex[k]));
      @(posedge clk); @(negedge clk);
      e = sbq.pop_front(); checks++;
      if ({gnt, s_0, s_1, owner, busy} !== {e.gnt, e.sel, e.sel, e.busy}) begin
        errors++;
        $display("FAIL release_idle[%0d]: gnt=%b sel=%b%b owner=%0d busy=%b want gnt=%b sel=%b busy=%b",
                 k, gnt, s_0, s_1, owner, busy, e.gnt, e.sel, e.busy);
      end
    end
  endtask

  // Owner re-request after a release, then a waiting requester that gives up.
  task automatic test_skip_rerequest();
    logic [3:0] rq [7] = '{4'b0100, 4'b0000, 4'b0100, 4'b1100, 4'b0100, 4'b0001, 4'b0000};
    logic [6:0] ex [7] = '{7'b0100_10_1, 7'b0000_10_0, 7'b0100_10_1, 7'b0100_10_1,
                           7'b0100_10_1, 7'b0001_00_1, 7'b0000_00_0};
    exp_t e;
    for (int k = 0; k < 7; k++) begin
      req = rq[k];
      sbq.push_back(exp_t'(ex[k]));
      @(posedge clk); @(negedge clk);
      e = sbq.pop_front(); checks++;
      if ({gnt, s_0, s_1, owner, busy} !== {e.gnt, e.sel, e.sel, e.busy}) begin
        errors++;
        $display("FAIL skip_rerequest[%0d]: gnt=%b sel=%b%b owner=%0d busy=%b want gnt=%b sel=%b busy=%b",
                 k, gnt, s_0, s_1, owner, busy, e.gnt, e.sel, e.busy);
      end
    end
  endtask

  task automatic test_hold();
    exp_t       e, x;
    logic [1:0] own;
    for (int k = 0; k < 40; k++) begin
      if (k < 16) begin
        req = 4'b0011;
`ifdef FOUR_WAY_ARB_HOLD_LIMIT_EN
        own = ((k / 4) % 2 == 0) ? 2'd1 : 2'd0;
`else
        own = 2'd1;
`endif
      end else begin
        req = 4'b0001;
        own = 2'd0;
      end
      x.gnt  = 4'b0001 << own;
      x.sel  = own;
      x.busy = 1'b1;
      sbq.push_back(x);
      @(posedge clk); @(negedge clk);
      e = sbq.pop_front(); checks++;
      if ({gnt, s_0, s_1, owner, busy} !== {e.gnt, e.sel, e.sel, e.busy}) begin
        errors++;
        $display("FAIL hold[%0d]: gnt=%b sel=%b%b owner=%0d busy=%b want gnt=%b sel=%b busy=%b",
                 k, gnt, s_0, s_1, owner, busy, e.gnt, e.sel, e.busy);
      end
    end
  endtask

  // Reset mid-grant must restore ptr=3 so requester 0 wins next, not 2.
  task automatic test_reset_mid_grant();
    logic       rs [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] rq [4] = '{4'b0010, 4'b1111, 4'b1111, 4'b0000};
    logic [6:0] ex [4] = '{7'b0010_01_1, 7'b0000_00_0, 7'b0001_00_1, 7'b0000_00_0};
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      rst_n = rs[k];
      req   = rq[k];
      sbq.push_back(exp_t'(ex[k]));
      @(posedge clk); @(negedge clk);
      e = sbq.pop_front(); checks++;
      if ({gnt, s_0, s_1, owner, busy} !== {e.gnt, e.sel, e.sel, e.busy}) begin
        errors++;
        $display("FAIL reset_mid_grant[%0d]: gnt=%b sel=%b%b owner=%0d busy=%b want gnt=%b sel=%b busy=%b",
                 k, gnt, s_0, s_1, owner, busy, e.gnt, e.sel, e.busy);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    test_reset();
    test_handoff();
    test_rotation();
    test_release_idle();
    test_skip_rerequest();
    test_hold();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/four_way_mux_arbiter.md
# four_way_mux_arbiter

Round-robin arbiter that shares one 4:1 select mux among four requesters. It sits directly in front of the mux, driving the `s_0`/`s_1` select pair from a registered grant so that exactly one requester's data reaches `OUT` at a time. Grants are held until the owner releases its request; an optional hold limit forces rotation under contention.

## Interface

Parameters:
- `MAX_HOLD`, default 8: maximum consecutive BUSY cycles for one owner when the hold limit is compiled in. Legal range is 2..255.

Ports:
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `req` input, 4 bits: request, one bit per requester; bit i maps to mux input `p_i`.
- `gnt` output, 4 bits: one-hot grant, registered; all zero when idle.
- `s_0` output, 1 bit: mux select MSB, registered.
- `s_1` output, 1 bit: mux select LSB, registered. The selected input index is {`s_0`,`s_1`}.
- `busy` output, 1 bit: high while any grant is active, registered.
- `owner` output, 2 bits: index of the current or last owner; equals {`s_0`,`s_1`}.

## Operation

- Two states.
  - IDLE: no grant.
  - BUSY: one grant active.
- Internal pointer `ptr` (2 bits) holds the last granted index. The search order is `ptr`+1, `ptr`+2, `ptr`+3, `ptr`, all mod 4, with wrap 3→0.
- Reset values:
  - state = IDLE, `gnt` = 4'b0000, `s_0` = `s_1` = 0, `busy` = 0, `ptr` = 3.
  - With `ptr` = 3 the first search starts at requester 0.
- IDLE:
  - If `req` ≠ 0, pick the winner W by search order.
  - Next edge: state = BUSY, `gnt` = 1<<W, {`s_0`,`s_1`} = W, `ptr` = W, `busy` = 1.
- BUSY, `req[owner]` still high: hold the grant. With the hold limit compiled in, see Configuration.
- BUSY, `req[owner]` low:
  - Search starts from `owner`+1 and excludes the owner.
  - If another request is found, hand the grant directly to the new winner on the next edge. There is no idle bubble and `busy` stays 1.
  - Otherwise go to IDLE: `gnt` = 0, `busy` = 0, and `s_0`/`s_1`/`ptr` keep their last values (the mux select does not glitch).
- Requests are level-sensitive. A requester deasserting before it is granted is simply skipped.
- Simultaneous release by the owner and a new request from the same index: the owner is excluded from the handoff search. If it is the only requester, it is re-granted from IDLE one cycle later.
- Invariants:
  - `gnt` is always one-hot or zero.
  - `gnt` ≠ 0 exactly when `busy` = 1.
  - When `busy` = 1, `gnt[{s_0,s_1}]` = 1.

## Timing

- Latency from `req` to `gnt` is 1 cycle from IDLE.
- Handoff: the owner drops `req` in cycle N; the new `gnt` is visible in cycle N+1.
- All outputs are registered, with no combinational path from `req` to any output.
- Reset is synchronous. Any edge with `rst_n` = 0 forces reset values regardless of state, including mid-grant; the hold counter is also cleared.

## Configuration

- Macro: `FOUR_WAY_ARB_HOLD_LIMIT_EN`.
- Defined:
  - An 8-bit `hold_cnt` clears on every new grant and increments each BUSY cycle.
  - When `hold_cnt` = `MAX_HOLD`−1 and another `req` bit is set, the grant is revoked from the owner and handed to the next winner on the next edge, even if `req[owner]` is still high.
  - If no other request is pending, `hold_cnt` saturates and the owner keeps the grant.
- Undefined: no counter is present and a grant is held for as long as `req[owner]` stays high. `MAX_HOLD` is ignored.

## Structure

- Package `four_way_arb_pkg`:
  - `NUM_REQ` = 4.
  - `idx_t` (2-bit index).
  - State enum `arb_state_t` {ARB_IDLE, ARB_BUSY}.
- Sub-module `rr_pick`: combinational rotating priority picker.
  - Inputs: `req` and `start` index.
  - Outputs: `found` and `idx`.
  - Instantiated once. The top module masks the owner bit before the handoff search.

## Test plan

- Reset, then `req` = 4'b1010 → one cycle later `gnt` = 4'b0010, {`s_0`,`s_1`} = 01, `busy` = 1.
- Owner 1 drops `req` while `req` = 4'b1000 → next cycle `gnt` = 4'b1000, {`s_0`,`s_1`} = 11, `busy` stays 1 with no gap.
- All four requesting, each releasing after 2 cycles of grant → grant order 0, 1, 2, 3, 0, with `ptr` wrapping 3→0.
- Owner 2 releases with no other `req` → `gnt` = 0, `busy` = 0, {`s_0`,`s_1`} held at 10.
- With `FOUR_WAY_ARB_HOLD_LIMIT_EN` defined and `MAX_HOLD` = 4, `req` = 4'b0011 held high → grant alternates 0 and 1 every 4 cycles. With `req` = 4'b0001 only, grant 0 is held for more than 20 cycles.
- `rst_n` low for 1 cycle mid-grant → next edge `gnt` = 0, `busy` = 0, select = 00. With `req` = 4'b1111 after release, the first grant goes to 0.
